// File: rtl/sram_ctrl.sv
// sram_ctrl: carries one 32-bit bus access at a time to an asynchronous 16-bit SRAM.
// Each access runs as a low-halfword phase and/or a high-halfword phase, each WAIT_CYCLES clocks long.

package sram_ctrl_pkg;
   typedef struct packed {
      logic        mem_valid;
      logic [31:0] mem_addr;
      logic [31:0] mem_wdata;
      logic [3:0]  mem_wstrb;
   } mem_in_type;

   typedef struct packed {
      logic        mem_ready;
      logic [31:0] mem_rdata;
   } mem_out_type;
endpackage

module sram_ctrl
   import sram_ctrl_pkg::*;
#(
   parameter int WAIT_CYCLES = 2,
   parameter int ADDR_BITS   = 21
) (
   input  logic                 clock,
   input  logic                 reset,
   input  mem_in_type           ram_in,
   output mem_out_type          ram_out,
   output logic [ADDR_BITS-2:0] sram_addr,
   output logic [15:0]          sram_dq_o,
   input  logic [15:0]          sram_dq_i,
   output logic                 sram_dq_oe,
   output logic                 sram_ce_n,
   output logic                 sram_oe_n,
   output logic                 sram_we_n,
   output logic                 sram_lb_n,
   output logic                 sram_ub_n
);

   typedef enum logic [1:0] {IDLE, LO, HI} state_e;

   typedef struct packed {
      logic [ADDR_BITS-2:0] addr;
      logic [15:0]          dq;
      logic                 dqOe;
      logic                 ceN;
      logic                 oeN;
      logic                 weN;
      logic                 lbN;
      logic                 ubN;
   } sramCtl_t;

   localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);
   localparam logic [3:0] HOLD_CNT = 4'(WAIT_CYCLES - 2);
   localparam sramCtl_t RESET_CTL = '{addr: '0, dq: '0, dqOe: 1'b0, ceN: 1'b1,
                                      oeN: 1'b1, weN: 1'b1, lbN: 1'b1, ubN: 1'b1};

   state_e               state_q;
   logic [3:0]           cnt_q;
   logic [ADDR_BITS-3:0] wordAddr_q;
   logic [31:0]          wdata_q;
   logic [3:0]           wstrb_q;
   logic                 isWrite_q;
   logic [15:0]          rdLo_q;
   logic                 ready_q;
   logic [31:0]          rdata_q;
   sramCtl_t             ctl_q;

   logic [ADDR_BITS-3:0] reqWordAddr;
   logic                 reqWrite;
   logic                 unusedAddrBits;

   assign reqWordAddr    = ram_in.mem_addr[ADDR_BITS-1:2];
   assign reqWrite       = |ram_in.mem_wstrb;
   assign unusedAddrBits = ^{ram_in.mem_addr[31:ADDR_BITS], ram_in.mem_addr[1:0]};

   // Pad settings for the first cycle of a phase; we_n is later raised for the hold cycle.
   function automatic sramCtl_t phaseCtl(input logic write, input logic hi,
                                         input logic [ADDR_BITS-3:0] wordAddr,
                                         input logic [3:0] strb, input logic [31:0] wdata);
      sramCtl_t c;
      c.addr = {wordAddr, hi};
      c.dq   = write ? (hi ? wdata[31:16] : wdata[15:0]) : 16'h0;
      c.dqOe = write;
      c.ceN  = 1'b0;
      c.oeN  = write;
      c.weN  = ~write;
      c.lbN  = write ? ~(hi ? strb[2] : strb[0]) : 1'b0;
      c.ubN  = write ? ~(hi ? strb[3] : strb[1]) : 1'b0;
      return c;
   endfunction

   function automatic sramCtl_t releaseCtl(input sramCtl_t cur);
      sramCtl_t c;
      c      = RESET_CTL;
      c.addr = cur.addr;
      c.dq   = cur.dq;
      return c;
   endfunction

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         wordAddr_q <= '0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         isWrite_q  <= 1'b0;
         rdLo_q     <= '0;
         ready_q    <= 1'b0;
         rdata_q    <= '0;
         ctl_q      <= RESET_CTL;
      end else begin
         ready_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (ram_in.mem_valid) begin
                  wordAddr_q <= reqWordAddr;
                  wdata_q    <= ram_in.mem_wdata;
                  wstrb_q    <= ram_in.mem_wstrb;
                  isWrite_q  <= reqWrite;
                  cnt_q      <= '0;
                  // A write touching only the upper halfword skips the LO phase entirely.
                  if (reqWrite && ram_in.mem_wstrb[1:0] == 2'b00) begin
                     state_q <= HI;
                     ctl_q   <= phaseCtl(1'b1, 1'b1, reqWordAddr, ram_in.mem_wstrb, ram_in.mem_wdata);
                  end else begin
                     state_q <= LO;
                     ctl_q   <= phaseCtl(reqWrite, 1'b0, reqWordAddr, ram_in.mem_wstrb, ram_in.mem_wdata);
                  end
               end
            end
            LO, HI: begin
               if (cnt_q != LAST_CNT) begin
                  cnt_q     <= cnt_q + 4'd1;
                  ctl_q.weN <= ~isWrite_q | (cnt_q == HOLD_CNT);
               end else if (state_q == LO) begin
                  rdLo_q <= sram_dq_i;
                  if (!isWrite_q || wstrb_q[3:2] != 2'b00) begin
                     state_q <= HI;
                     cnt_q   <= '0;
                     ctl_q   <= phaseCtl(isWrite_q, 1'b1, wordAddr_q, wstrb_q, wdata_q);
                  end else begin
                     state_q <= IDLE;
                     ctl_q   <= releaseCtl(ctl_q);
                     ready_q <= 1'b1;
                     rdata_q <= '0;
                  end
               end else begin
                  state_q <= IDLE;
                  ctl_q   <= releaseCtl(ctl_q);
                  ready_q <= 1'b1;
                  rdata_q <= isWrite_q ? 32'h0 : {sram_dq_i, rdLo_q};
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

`ifndef SYNTHESIS
   // The bus may not issue while an access is in flight; such a request is dropped.
   always_ff @(posedge clock) begin
      if (!reset && state_q != IDLE)
         assert (!ram_in.mem_valid) else $warning("sram_ctrl: mem_valid while busy, request dropped");
   end
`endif

   assign ram_out    = '{mem_ready: ready_q, mem_rdata: rdata_q};
   assign sram_addr  = ctl_q.addr;
   assign sram_dq_o  = ctl_q.dq;
   assign sram_dq_oe = ctl_q.dqOe;
   assign sram_ce_n  = ctl_q.ceN;
   assign sram_oe_n  = ctl_q.oeN;
   assign sram_we_n  = ctl_q.weN;
   assign sram_lb_n  = ctl_q.lbN;
   assign sram_ub_n  = ctl_q.ubN;

endmodule
